// File: rtl/bp_host_io_mmio_multi_pkg.sv
// Shared types and constants for the host MMIO endpoint: command/response message layout,
// the decoded address map, the getchar-empty value and the console drain state encoding.
package bp_host_io_mmio_multi_pkg;

  localparam int paddr_width_p  = 40;
  localparam int data_width_p   = 64;
  localparam int num_core_def_p = 3;
  localparam int domain_width_p = 3;

  typedef struct packed {
    logic [3:0]               msg_type;
    logic [paddr_width_p-1:0] addr;
  } bp_io_hdr_s;

  typedef struct packed {
    bp_io_hdr_s              hdr;
    logic [data_width_p-1:0] data;
  } bp_io_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_io_msg_s);

  localparam logic [paddr_width_p-1:0] getchar_addr_gp = paddr_width_p'(32'h0010_0000);
  localparam logic [paddr_width_p-1:0] putchar_base_gp = paddr_width_p'(32'h0010_1000);
  localparam logic [paddr_width_p-1:0] finish_base_gp  = paddr_width_p'(32'h0010_2000);
  localparam logic [data_width_p-1:0]  getchar_empty_gp = '1;

  typedef enum logic {
    e_drain_idle,
    e_drain_burst
  } drain_state_e;

endpackage

// File: rtl/bp_host_io_mmio_multi_if.sv
// I/O command/response channel between a host-side master and the MMIO endpoint.
interface bp_host_io_mmio_multi_if;
  import bp_host_io_mmio_multi_pkg::*;

  bp_io_msg_s cmd;
  logic       cmd_v;
  logic       cmd_ready;
  bp_io_msg_s resp;
  logic       resp_v;
  logic       resp_yumi;

  modport master (output cmd, cmd_v, resp_yumi, input cmd_ready, resp, resp_v);
  modport slave  (input cmd, cmd_v, resp_yumi, output cmd_ready, resp, resp_v);
endinterface

// File: rtl/bp_host_io_mmio_multi_line_buffer.sv
// Byte FIFO with a sticky flush request: set by a newline push, by filling up, or externally
// while data remains; last_o marks the byte whose pop empties the buffer.
module bp_host_line_buffer #(
  parameter int els_p      = 64,
  parameter bit flush_en_p = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       push_v_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  input  logic       flush_set_i,
  input  logic       flush_clr_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       last_o,
  output logic       flush_o
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [7:0]          mem_q [els_p];
  logic [ptr_w_lp-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [ptr_w_lp:0]   cnt_q, cnt_d;
  logic                flush_q, flush_d, do_push, do_pop;

  assign full_o  = (cnt_q == (ptr_w_lp+1)'(els_p));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_v_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];
  // A byte pushed alongside the pop keeps the buffer occupied, so the popped byte is not last.
  assign last_o  = (cnt_q == (ptr_w_lp+1)'(1)) & ~do_push;
  assign flush_o = flush_q;

  always_comb begin
    rd_d    = rd_q + ptr_w_lp'(do_pop);
    wr_d    = wr_q + ptr_w_lp'(do_push);
    cnt_d   = cnt_q + (ptr_w_lp+1)'(do_push) - (ptr_w_lp+1)'(do_pop);
    flush_d = flush_en_p & ((flush_q & ~flush_clr_i)
            | (do_push & ((push_data_i == 8'h0A) | (cnt_d == (ptr_w_lp+1)'(els_p))))
            | (flush_set_i & (cnt_d != '0)));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end
endmodule

// File: rtl/bp_host_io_mmio_multi.sv
// Host MMIO endpoint: getchar from an RX stream, per-core line-buffered putchar drained
// round-robin to one TX stream, per-core finish/fail flags and an illegal-access counter.
module bp_host_io_mmio_multi
  import bp_host_io_mmio_multi_pkg::*;
#(
  parameter int num_core_p  = num_core_def_p,
  parameter int line_els_p  = 64,
  parameter int rx_els_p    = 16,
  parameter int cnt_width_p = 16,
  localparam int core_w_lp  = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  bp_host_io_mmio_multi_if.slave io,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_v_i,
  output logic                   rx_ready_o,
  output logic [7:0]             tx_data_o,
  output logic [core_w_lp-1:0]   tx_core_id_o,
  output logic                   tx_last_o,
  output logic                   tx_v_o,
  input  logic                   tx_ready_i,
  output logic [num_core_p-1:0]  finish_o,
  output logic [num_core_p-1:0]  fail_o,
  output logic                   all_finished_o,
  output logic [cnt_width_p-1:0] illegal_cnt_o
);
  localparam logic [paddr_width_p-1:0] core_mask_lp =
    paddr_width_p'(((1 << core_w_lp) - 1) << 3);

  logic [paddr_width_p-1:0] addr, addr_base;
  logic [core_w_lp-1:0]     core_id;
  logic is_getchar, is_putchar, is_finish, is_bad, domain_ok, core_ok, accept;

  logic [num_core_p-1:0] lb_push, lb_pop, lb_full, lb_empty, lb_last, lb_flush;
  logic [num_core_p-1:0] lb_fin_set, lb_clr;
  logic [7:0]            lb_data [num_core_p];

  logic [7:0] rx_data;
  logic       rx_full, rx_empty, rx_pop, unused_rx_last, unused_rx_flush, unused_rx;

  bp_io_msg_s            resp_q, resp_d;
  logic                  resp_v_q;
  logic [num_core_p-1:0] finish_q, fail_q, finish_hit;
  logic                  all_finished_q;
  logic [cnt_width_p-1:0] ill_q;

  drain_state_e         state_q, state_d;
  logic [core_w_lp-1:0] grant_q, grant_d, rr_q, rr_d, pick;
  logic                 found;
  int                   idx;

  assign addr       = io.cmd.hdr.addr;
  assign core_id    = addr[3 +: core_w_lp];
  assign addr_base  = addr & ~core_mask_lp;
  assign domain_ok  = (addr[paddr_width_p-1 -: domain_width_p] == '0);
  assign core_ok    = ({1'b0, core_id} < (core_w_lp+1)'(num_core_p));
  assign is_getchar = domain_ok & (addr == getchar_addr_gp);
  assign is_putchar = domain_ok & core_ok & (addr_base == putchar_base_gp);
  assign is_finish  = domain_ok & core_ok & (addr_base == finish_base_gp);
  assign is_bad     = ~(is_getchar | is_putchar | is_finish);

  assign io.cmd_ready = (~resp_v_q | io.resp_yumi) & ~(is_putchar & lb_full[core_id]);
  assign accept       = io.cmd_v & io.cmd_ready;
  assign rx_pop       = accept & is_getchar & ~rx_empty;
  assign io.resp      = resp_q;
  assign io.resp_v    = resp_v_q;

  for (genvar c = 0; c < num_core_p; c++) begin : g_line
    assign lb_push[c]    = accept & is_putchar & (core_id == core_w_lp'(c));
    assign lb_fin_set[c] = accept & is_finish & (core_id == core_w_lp'(c));
    assign lb_pop[c]     = tx_v_o & tx_ready_i & (grant_q == core_w_lp'(c));
    assign finish_hit[c] = lb_fin_set[c];

    bp_host_line_buffer #(.els_p(line_els_p), .flush_en_p(1'b1)) u_lb (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .push_v_i(lb_push[c]), .push_data_i(io.cmd.data[7:0]), .pop_i(lb_pop[c]),
      .flush_set_i(lb_fin_set[c]), .flush_clr_i(lb_clr[c]),
      .data_o(lb_data[c]), .full_o(lb_full[c]), .empty_o(lb_empty[c]),
      .last_o(lb_last[c]), .flush_o(lb_flush[c])
    );
  end

  bp_host_line_buffer #(.els_p(rx_els_p), .flush_en_p(1'b0)) u_rx (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .push_v_i(rx_v_i & rx_ready_o), .push_data_i(rx_data_i), .pop_i(rx_pop),
    .flush_set_i(1'b0), .flush_clr_i(1'b0),
    .data_o(rx_data), .full_o(rx_full), .empty_o(rx_empty),
    .last_o(unused_rx_last), .flush_o(unused_rx_flush)
  );
  assign unused_rx  = unused_rx_last ^ unused_rx_flush;
  assign rx_ready_o = ~rx_full;

  always_comb begin
    resp_d     = '0;
    resp_d.hdr = io.cmd.hdr;
    if (is_getchar) resp_d.data = rx_empty ? getchar_empty_gp : {56'd0, rx_data};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_v_q       <= 1'b0;
      resp_q         <= '0;
      finish_q       <= '0;
      fail_q         <= '0;
      all_finished_q <= 1'b0;
      ill_q          <= '0;
    end else begin
      if (accept) begin
        resp_v_q <= 1'b1;
        resp_q   <= resp_d;
      end else if (io.resp_yumi) begin
        resp_v_q <= 1'b0;
      end
      finish_q       <= finish_q | finish_hit;
      fail_q         <= fail_q | (finish_hit & {num_core_p{io.cmd.data[7:0] != 8'h00}});
      all_finished_q <= (&finish_q) & (&lb_empty) & (state_q == e_drain_idle);
      if (accept & is_bad & ~(&ill_q)) ill_q <= ill_q + 1'b1;
    end
  end

  // Drain arbiter: pick the first flushing core at or after rr, then stream it until empty.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    tx_v_o  = 1'b0;
    lb_clr  = '0;
    pick    = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < num_core_p; i++) begin
      idx = (int'(rr_q) + i) % num_core_p;
      if (!found && lb_flush[idx]) begin
        found = 1'b1;
        pick  = core_w_lp'(idx);
      end
    end
    case (state_q)
      e_drain_idle: begin
        if (found) begin
          state_d = e_drain_burst;
          grant_d = pick;
          rr_d    = (int'(pick) == num_core_p - 1) ? '0 : pick + 1'b1;
        end
      end
      e_drain_burst: begin
        tx_v_o = 1'b1;
        if (tx_ready_i && lb_last[grant_q]) begin
          state_d         = e_drain_idle;
          lb_clr[grant_q] = 1'b1;
        end
      end
      default: state_d = e_drain_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_drain_idle;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign tx_data_o      = tx_v_o ? lb_data[grant_q] : 8'h00;
  assign tx_core_id_o   = tx_v_o ? grant_q : '0;
  assign tx_last_o      = tx_v_o & lb_last[grant_q];
  assign finish_o       = finish_q;
  assign fail_o         = fail_q;
  assign all_finished_o = all_finished_q;
  assign illegal_cnt_o  = ill_q;
endmodule

// File: tb/tb_bp_host_io_mmio_multi.sv
// Bench for the host MMIO endpoint: per-scenario tasks with randomized bytes, checked against
// a queue-based console/RX model and a round-robin grant model.
module tb_bp_host_io_mmio_multi;
  import bp_host_io_mmio_multi_pkg::*;

  localparam int NC = 3;
  localparam int LE = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_host_io_mmio_multi_if io_if();

  logic [7:0]    rx_data, tx_data;
  logic          rx_v, rx_ready, tx_last, tx_v, tx_ready, all_fin;
  logic [1:0]    tx_id;
  logic [NC-1:0] finish, fail;
  logic [CW-1:0] ill_cnt;

  bp_host_io_mmio_multi #(.num_core_p(NC), .line_els_p(LE), .rx_els_p(16), .cnt_width_p(CW)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .io(io_if),
    .rx_data_i(rx_data), .rx_v_i(rx_v), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_core_id_o(tx_id), .tx_last_o(tx_last), .tx_v_o(tx_v),
    .tx_ready_i(tx_ready), .finish_o(finish), .fail_o(fail),
    .all_finished_o(all_fin), .illegal_cnt_o(ill_cnt)
  );

  typedef struct {logic [7:0] d; int id; logic last;} tx_rec_t;

  int         n_cmp = 0;
  int         n_fail = 0;
  tx_rec_t    txq[$];
  tx_rec_t    exq[$];
  logic [7:0] mq[NC][$];
  logic [7:0] rxq[$];
  int         rr;
  int         ill;

  always @(posedge clk) if (rst_n && tx_v && tx_ready) txq.push_back('{tx_data, int'(tx_id), tx_last});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [39:0] put_a(input int c); return 40'h0010_1000 + 40'(8 * c); endfunction
  function automatic logic [39:0] fin_a(input int c); return 40'h0010_2000 + 40'(8 * c); endfunction

  // Round-robin model: first pending core at or after rr, then rr moves past it.
  function automatic int next_grant(input logic [NC-1:0] pend);
    for (int i = 0; i < NC; i++) begin
      if (pend[(rr + i) % NC]) begin
        next_grant = (rr + i) % NC;
        rr = (next_grant + 1) % NC;
        return next_grant;
      end
    end
    return -1;
  endfunction

  // Expected burst for a core: all buffered bytes in order, last flag on the final one.
  task automatic model_flush(input int c);
    int n;
    n = mq[c].size();
    for (int i = 0; i < n; i++) exq.push_back('{mq[c].pop_front(), c, (i == n - 1)});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    io_if.cmd_v = 1'b0; io_if.resp_yumi = 1'b0; io_if.cmd = '0;
    rx_v = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < NC; c++) mq[c].delete();
    rxq.delete(); txq.delete(); exq.delete();
    rr = 0; ill = 0;
  endtask

  task automatic do_cmd(input logic [39:0] addr, input logic [63:0] data,
                        output logic [63:0] rdata, output logic hdr_ok, output logic ok);
    bp_io_hdr_s hdr;
    int n;
    hdr.msg_type = 4'($urandom);
    hdr.addr = addr;
    io_if.cmd.hdr = hdr; io_if.cmd.data = data; io_if.cmd_v = 1'b1;
    n = 0;
    #1;
    while (!io_if.cmd_ready && n < 100) begin @(negedge clk); #1; n++; end
    if (!io_if.cmd_ready) begin
      io_if.cmd_v = 1'b0; rdata = '0; hdr_ok = 1'b0; ok = 1'b0;
      @(negedge clk);
      return;
    end
    @(negedge clk);
    io_if.cmd_v = 1'b0;
    ok = io_if.resp_v;
    rdata = io_if.resp.data;
    hdr_ok = (io_if.resp.hdr === hdr);
    io_if.resp_yumi = 1'b1;
    @(negedge clk);
    io_if.resp_yumi = 1'b0;
  endtask

  task automatic wait_tx(input int n, output logic ok);
    int k = 0;
    while (txq.size() < n && k < 200) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    ok = (txq.size() >= n);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({io_if.resp_v, tx_v, finish, fail, all_fin, ill_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got resp_v=%b tx_v=%b fin=%b fail=%b allf=%b ill=%0d, required all 0",
               io_if.resp_v, tx_v, finish, fail, all_fin, ill_cnt);
    end
    apply_reset();
    n_cmp++;
    if (rx_ready !== 1'b1 || io_if.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got rx_ready=%b cmd_ready=%b, required 1 1", rx_ready, io_if.cmd_ready);
    end
  endtask

  task automatic test_putchar();
    logic [63:0] rd; logic hok, ok; logic [7:0] b; int c, len; tx_rec_t r, e;
    logic [7:0] line[$];
    tx_ready = 1'b1;
    for (int round = 0; round < 3; round++) begin
      line.delete();
      if (round == 0) begin c = 0; line = '{8'h48, 8'h69, 8'h0A}; end
      else begin
        c = $urandom_range(0, NC - 1);
        len = $urandom_range(1, LE - 1);
        for (int i = 0; i < len; i++) begin b = 8'($urandom_range(8'h20, 8'h7E)); line.push_back(b); end
        line.push_back(8'h0A);
      end
      foreach (line[i]) begin
        do_cmd(put_a(c), {$urandom, 24'h0, line[i]}, rd, hok, ok);
        mq[c].push_back(line[i]);
        n_cmp++;
        if (!ok || !hok || rd !== 64'h0) begin
          n_fail++; $display("FAIL putchar_resp: got ok=%b hdr_ok=%b data=%h, required 1 1 0", ok, hok, rd);
        end
      end
      void'(next_grant(NC'(1) << c));
      wait_tx(line.size(), ok);
      model_flush(c);
      while (exq.size() > 0) begin
        e = exq.pop_front();
        n_cmp++;
        if (txq.size() == 0) begin n_fail++; $display("FAIL putchar_tx: no byte, required %h", e.d); end
        else begin
          r = txq.pop_front();
          if (r.d !== e.d || r.id != e.id || r.last !== e.last) begin
            n_fail++; $display("FAIL putchar_tx: got d=%h id=%0d last=%b, required d=%h id=%0d last=%b",
                               r.d, r.id, r.last, e.d, e.id, e.last);
          end
        end
      end
      n_cmp++;
      if (txq.size() != 0) begin n_fail++; $display("FAIL putchar_extra: got %0d extra bytes, required 0", txq.size()); end
    end
  endtask

  task automatic test_full_stall();
    logic [63:0] rd; logic hok, ok; bp_io_hdr_s hdr; tx_rec_t r, e; int stall;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_cmd(put_a(1), 64'(8'h61 + i), rd, hok, ok);
      mq[1].push_back(8'(8'h61 + i));
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({tx_v, tx_data, tx_id} !== {1'b1, 8'h61, 2'd1}) begin
      n_fail++; $display("FAIL full_burst_start: got v=%b d=%h id=%0d, required 1 61 1", tx_v, tx_data, tx_id);
    end
    hdr.msg_type = 4'h0; hdr.addr = put_a(1);
    io_if.cmd.hdr = hdr; io_if.cmd.data = 64'h65; io_if.cmd_v = 1'b1;
    stall = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); #1; if (!io_if.cmd_ready) stall++; end
    io_if.cmd_v = 1'b0;
    n_cmp++;
    if (stall != 4) begin n_fail++; $display("FAIL full_stall: got %0d stalled cycles, required 4", stall); end
    tx_ready = 1'b1;
    void'(next_grant(3'b010));
    wait_tx(4, ok);
    model_flush(1);
    do_cmd(put_a(1), 64'h65, rd, hok, ok);
    mq[1].push_back(8'h65);
    do_cmd(put_a(1), 64'h0A, rd, hok, ok);
    mq[1].push_back(8'h0A);
    n_cmp++;
    if (!ok || rd !== 64'h0) begin n_fail++; $display("FAIL full_after: got ok=%b data=%h, required 1 0", ok, rd); end
    void'(next_grant(3'b010));
    model_flush(1);
    wait_tx(6, ok);
    while (exq.size() > 0) begin
      e = exq.pop_front();
      n_cmp++;
      if (txq.size() == 0) begin n_fail++; $display("FAIL full_tx: no byte, required %h", e.d); end
      else begin
        r = txq.pop_front();
        if (r.d !== e.d || r.id != e.id || r.last !== e.last) begin
          n_fail++; $display("FAIL full_tx: got d=%h id=%0d last=%b, required d=%h id=%0d last=%b",
                             r.d, r.id, r.last, e.d, e.id, e.last);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [63:0] rd; logic hok, ok; tx_rec_t r, e; int order[3]; int g; logic [NC-1:0] pend;
    apply_reset();
    for (int round = 0; round < 2; round++) begin
      tx_ready = 1'b0;
      order = (round == 0) ? '{2, 0, 1} : '{2, 1, 0};
      foreach (order[k]) begin
        mq[order[k]].push_back(8'($urandom_range(8'h30, 8'h39)));
        mq[order[k]].push_back(8'h0A);
        do_cmd(put_a(order[k]), 64'(mq[order[k]][0]), rd, hok, ok);
        do_cmd(put_a(order[k]), 64'h0A, rd, hok, ok);
      end
      // Core 2 is granted alone; cores 0 and 1 then tie behind it.
      g = next_grant(3'b100);
      model_flush(g);
      pend = 3'b011;
      while (pend != 0) begin g = next_grant(pend); pend[g] = 1'b0; model_flush(g); end
      tx_ready = 1'b1;
      wait_tx(6, ok);
      while (exq.size() > 0) begin
        e = exq.pop_front();
        n_cmp++;
        if (txq.size() == 0) begin n_fail++; $display("FAIL rr_tx: no byte, required %h", e.d); end
        else begin
          r = txq.pop_front();
          if (r.d !== e.d || r.id != e.id || r.last !== e.last) begin
            n_fail++; $display("FAIL rr_tx: got d=%h id=%0d last=%b, required d=%h id=%0d last=%b",
                               r.d, r.id, r.last, e.d, e.id, e.last);
          end
        end
      end
    end
  endtask

  task automatic test_getchar();
    logic [63:0] rd, exp; logic hok, ok; logic [7:0] b;
    do_cmd(40'h0010_0000, 64'h0, rd, hok, ok);
    n_cmp++;
    if (!ok || !hok || rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL getchar_empty: got ok=%b hdr_ok=%b data=%h, required all-ones", ok, hok, rd);
    end
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom); rxq.push_back(b);
      rx_data = b; rx_v = 1'b1; @(negedge clk); rx_v = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      do_cmd(40'h0010_0000, 64'h0, rd, hok, ok);
      exp = {56'h0, rxq.pop_front()};
      n_cmp++;
      if (rd !== exp) begin n_fail++; $display("FAIL getchar_data: got %h, required %h", rd, exp); end
    end
    // RX push and getchar pop accepted on the same edge.
    b = 8'($urandom);
    rx_data = b; rx_v = 1'b1;
    io_if.cmd.hdr.addr = 40'h0010_0000; io_if.cmd.data = '0; io_if.cmd_v = 1'b1;
    @(negedge clk);
    rx_v = 1'b0; io_if.cmd_v = 1'b0;
    exp = {56'h0, rxq.pop_front()};
    rxq.push_back(b);
    n_cmp++;
    if (io_if.resp_v !== 1'b1 || io_if.resp.data !== exp) begin
      n_fail++; $display("FAIL getchar_same_cycle: got v=%b data=%h, required 1 %h", io_if.resp_v, io_if.resp.data, exp);
    end
    io_if.resp_yumi = 1'b1; @(negedge clk); io_if.resp_yumi = 1'b0;
    do_cmd(40'h0010_0000, 64'h0, rd, hok, ok);
    exp = {56'h0, rxq.pop_front()};
    n_cmp++;
    if (rd !== exp) begin n_fail++; $display("FAIL getchar_order: got %h, required %h", rd, exp); end
    do_cmd(40'h0010_0000, 64'h0, rd, hok, ok);
    n_cmp++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL getchar_drained: got %h, required all-ones", rd); end
  endtask

  task automatic test_finish();
    logic [63:0] rd; logic hok, ok; logic [NC-1:0] efin, efail; logic [7:0] code;
    apply_reset();
    tx_ready = 1'b1;
    efin = '0; efail = '0;
    do_cmd(fin_a(0), 64'h0, rd, hok, ok); efin[0] = 1'b1;
    do_cmd(fin_a(1), 64'h3, rd, hok, ok); efin[1] = 1'b1; efail[1] = 1'b1;
    n_cmp++;
    if ({finish, fail, all_fin, rd} !== {efin, efail, 1'b0, 64'h0}) begin
      n_fail++; $display("FAIL finish_two: got fin=%b fail=%b allf=%b data=%h, required %b %b 0 0",
                         finish, fail, all_fin, rd, efin, efail);
    end
    io_if.cmd.hdr.addr = fin_a(2); io_if.cmd.data = 64'h0; io_if.cmd_v = 1'b1;
    @(posedge clk); #1;
    io_if.cmd_v = 1'b0; efin[2] = 1'b1;
    n_cmp++;
    if (finish !== efin || all_fin !== 1'b0) begin
      n_fail++; $display("FAIL finish_lag0: got fin=%b allf=%b, required %b 0", finish, all_fin, efin);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (all_fin !== 1'b1) begin n_fail++; $display("FAIL finish_lag1: got allf=%b, required 1", all_fin); end
    @(negedge clk);
    io_if.resp_yumi = 1'b1; @(negedge clk); io_if.resp_yumi = 1'b0;
    do_cmd(fin_a(1), 64'h0, rd, hok, ok);
    code = 8'($urandom_range(1, 255));
    do_cmd(fin_a(0), 64'(code), rd, hok, ok); efail[0] = 1'b1;
    n_cmp++;
    if (fail !== efail || finish !== efin) begin
      n_fail++; $display("FAIL finish_sticky: got fin=%b fail=%b, required %b %b", finish, fail, efin, efail);
    end
  endtask

  task automatic test_illegal();
    logic [63:0] rd; logic hok, ok; bp_io_hdr_s hdr; int held; logic [39:0] bad[3];
    hdr.msg_type = 4'h5; hdr.addr = {3'b001, 37'h0010_0000};
    io_if.cmd.hdr = hdr; io_if.cmd.data = 64'(~$urandom); io_if.cmd_v = 1'b1;
    @(negedge clk);
    io_if.cmd_v = 1'b0;
    held = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (io_if.resp_v === 1'b1 && io_if.resp.hdr === hdr && io_if.resp.data === 64'h0 && io_if.cmd_ready === 1'b0) held++;
    end
    ill = (ill < 3) ? ill + 1 : 3;
    n_cmp++;
    if (held != 3) begin n_fail++; $display("FAIL illegal_hold: got %0d stable cycles, required 3", held); end
    n_cmp++;
    if (ill_cnt !== CW'(ill)) begin n_fail++; $display("FAIL illegal_cnt1: got %0d, required %0d", ill_cnt, ill); end
    @(negedge clk);
    io_if.resp_yumi = 1'b1; @(negedge clk); io_if.resp_yumi = 1'b0;
    bad = '{put_a(3), fin_a(3), 40'h0010_3000 + 40'($urandom_range(0, 255) * 8)};
    for (int i = 0; i < 3; i++) begin
      do_cmd(bad[i], {32'($urandom), 32'($urandom)}, rd, hok, ok);
      ill = (ill < 3) ? ill + 1 : 3;
      n_cmp++;
      if (!ok || !hok || rd !== 64'h0 || ill_cnt !== CW'(ill)) begin
        n_fail++; $display("FAIL illegal_unmapped: got ok=%b hdr_ok=%b data=%h cnt=%0d, required 1 1 0 %0d",
                           ok, hok, rd, ill_cnt, ill);
      end
    end
    n_cmp++;
    if (tx_v !== 1'b0 || txq.size() != 0) begin
      n_fail++; $display("FAIL illegal_side: got tx_v=%b tx bytes=%0d, required 0 0", tx_v, txq.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] rd; logic hok, ok;
    apply_reset();
    tx_ready = 1'b0;
    do_cmd(put_a(0), 64'h78, rd, hok, ok);
    do_cmd(put_a(0), 64'h0A, rd, hok, ok);
    @(negedge clk); #1;
    n_cmp++;
    if (tx_v !== 1'b1) begin n_fail++; $display("FAIL midburst_active: got tx_v=%b, required 1", tx_v); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx_v !== 1'b0) begin n_fail++; $display("FAIL midburst_async: got tx_v=%b, required 0", tx_v); end
    @(negedge clk);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (txq.size() != 0 || tx_v !== 1'b0) begin
      n_fail++; $display("FAIL midburst_flushed: got %0d bytes tx_v=%b, required 0 0", txq.size(), tx_v);
    end
  endtask

  initial begin
    io_if.cmd = '0; io_if.cmd_v = 1'b0; io_if.resp_yumi = 1'b0;
    rx_data = 8'h00; rx_v = 1'b0; tx_ready = 1'b0;
    test_reset();
    test_putchar();
    test_full_stall();
    test_round_robin();
    test_getchar();
    test_finish();
    test_illegal();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
